force_wb_arbiter: RTL

FORCE_WB_ARBITER -- requirements
Module: force_wb_arbiter

---
 rtl/md_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/force_wb_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared types and default sizing for the force writeback arbiter.
package md_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int WB_ID_W        = 16;
  localparam int WB_FORCE_W     = 32;

  typedef struct packed {
    logic [WB_ID_W-1:0]    id;
    logic [WB_FORCE_W-1:0] force_val;
  } force_wb_t;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } arb_state_t;

  // Round-robin successor of idx among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO, combinational head read; a push into a full FIFO is
// taken only when the same cycle pops, otherwise it is ignored here.
module wb_fifo
  import md_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  force_wb_t                  din_i,
  output force_wb_t                  dout_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  force_wb_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // DEPTH is a power of two, so natural pointer overflow is the exact wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/force_wb_arbiter.sv
// Round-robin merge of per-requester writeback FIFOs onto one bus; 2-cycle latency,
// output register holds under bus_ready low. FORCE_WB_ARB_PERF_EN adds stall/xfer counters.
module force_wb_arbiter
  import md_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  force_wb_t [NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_done,
  output logic [NUM_REQ-1:0]      req_ready,
  output force_wb_t               bus_data,
  output logic                    bus_valid,
  input  logic                    bus_ready,
  output logic [NUM_REQ-1:0]      overflow,
  output logic                    all_done
`ifdef FORCE_WB_ARB_PERF_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             xfer_cnt
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(FIFO_DEPTH+1);

  force_wb_t          fifo_dout  [NUM_REQ];
  logic [CW-1:0]      fifo_count [NUM_REQ];
  logic [NUM_REQ-1:0] fifo_empty, fifo_full, pop;

  force_wb_t          bus_data_q, bus_data_d;
  logic               bus_valid_q, bus_valid_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] overflow_q, overflow_d;
  logic [NUM_REQ-1:0] done_seen_q, done_seen_d;
  arb_state_t         state_q, state_d;

  logic               load, grant_vld;
  logic [IW-1:0]      grant_idx, cand;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (req_valid[i]),
      .pop_i   (pop[i]),
      .din_i   (req_data[i]),
      .dout_o  (fifo_dout[i]),
      .empty_o (fifo_empty[i]),
      .full_o  (fifo_full[i]),
      .count_o (fifo_count[i])
    );
    // Two free slots keep one cycle of slack for the unhandshaked producer.
    assign req_ready[i] = (fifo_count[i] <= CW'(FIFO_DEPTH-2));
  end

  assign load = !bus_valid_q || bus_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_vld && !fifo_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    bus_valid_d = bus_valid_q;
    bus_data_d  = bus_data_q;
    rr_ptr_d    = rr_ptr_q;
    pop         = '0;
    if (load) begin
      bus_valid_d = grant_vld;
      if (grant_vld) begin
        bus_data_d     = fifo_dout[grant_idx];
        pop[grant_idx] = 1'b1;
        rr_ptr_d       = IW'(rr_next(int'(grant_idx), NUM_REQ));
      end
    end
  end

  assign overflow_d = overflow_q | (req_valid & fifo_full & ~pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      rr_ptr_q    <= '0;
      overflow_q  <= '0;
    end else begin
      bus_valid_q <= bus_valid_d;
      bus_data_q  <= bus_data_d;
      rr_ptr_q    <= rr_ptr_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    done_seen_d = done_seen_q;
    all_done    = 1'b0;
    case (state_q)
      COLLECT: begin
        done_seen_d = done_seen_q | req_done;
        if (&done_seen_d) state_d = DRAIN;
      end
      DRAIN: begin
        if (&fifo_empty && !bus_valid_q) begin
          all_done    = 1'b1;
          done_seen_d = '0;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      done_seen_q <= '0;
    end else begin
      state_q     <= state_d;
      done_seen_q <= done_seen_d;
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_data  = bus_data_q;
  assign overflow  = overflow_q;

`ifdef FORCE_WB_ARB_PERF_EN
  logic [31:0] stall_cnt_q, xfer_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      if (bus_valid_q && !bus_ready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus_valid_q && bus_ready && (xfer_cnt_q != '1))   xfer_cnt_q  <= xfer_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign xfer_cnt  = xfer_cnt_q;
`endif

endmodule
